// File: rtl/shreg_pkg.sv
// Shared types and limits for the universal shift register.
package shreg_pkg;

  // Operation select codes. All four 2-bit values are defined.
  typedef enum logic [1:0] {
    HOLD     = 2'b00,
    SHIFT_UP = 2'b01,
    SHIFT_DN = 2'b10,
    LOAD     = 2'b11
  } shreg_mode_t;

  // Largest supported register depth.
  localparam int SHREG_MAX_DEPTH = 64;

endpackage

// File: rtl/shreg_cell.sv
// One storage stage: 4:1 next-value mux feeding a synchronously cleared flop.
module shreg_cell
  import shreg_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n_i,
  input  logic [1:0]  sel_i,
  input  logic        from_below_i,
  input  logic        from_above_i,
  input  logic        load_val_i,
  output logic        q_o
);

  shreg_mode_t sel_e;
  logic        bit_q;
  logic        bit_d;

  assign sel_e = shreg_mode_t'(sel_i);

  // Pick the stage's next value from the operation select.
  always_comb begin
    bit_d = bit_q;
    case (sel_e)
      HOLD:     bit_d = bit_q;
      SHIFT_UP: bit_d = from_below_i;
      SHIFT_DN: bit_d = from_above_i;
      LOAD:     bit_d = load_val_i;
      default:  bit_d = bit_q;
    endcase
  end

  // Storage flop; clear wins over every operation.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: bidirectional shift, parallel load/readout,
// saturating shift counter and a one-cycle frame-done strobe.
// Optional rotate mode is enabled by defining SHREG_ROTATE_EN.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic [DEPTH-1:0] pdata,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [DEPTH-1:0] q,
  output logic             sout_lo,
  output logic             sout_hi,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  // Reject depths outside the supported range at elaboration.
  if (DEPTH < 2 || DEPTH > SHREG_MAX_DEPTH) begin : g_depth_check
    $error("univ_shift_reg: DEPTH out of range 2..64");
  end

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  shreg_mode_t      mode_e;
  logic [DEPTH-1:0] q_q;
  logic             feed_lo;
  logic             feed_hi;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;
  logic             shifting;

  assign mode_e   = shreg_mode_t'(mode);
  assign shifting = (mode_e == SHIFT_UP) || (mode_e == SHIFT_DN);

  // End-stage serial feeds: rotate closes the ring, otherwise serial inputs.
`ifdef SHREG_ROTATE_EN
  assign feed_lo = rot ? q_q[DEPTH-1] : sin_lo;
  assign feed_hi = rot ? q_q[0]       : sin_hi;
`else
  assign feed_lo = sin_lo;
  assign feed_hi = sin_hi;
`endif

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic below;
    logic above;

    if (gi == 0) begin : g_lo_end
      assign below = feed_lo;
    end else begin : g_lo_mid
      assign below = q_q[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_hi_end
      assign above = feed_hi;
    end else begin : g_hi_mid
      assign above = q_q[gi+1];
    end

    shreg_cell u_cell (
      .clk          (clk),
      .clr_n_i      (clr),
      .sel_i        (mode),
      .from_below_i (below),
      .from_above_i (above),
      .load_val_i   (pdata[gi]),
      .q_o          (q_q[gi])
    );
  end

  // Shift counter saturates at DEPTH; done fires only on the DEPTH-1 -> DEPTH step.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (mode_e == LOAD) begin
      cnt_d = '0;
    end else if (shifting && (cnt_q != CNT_FULL)) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  // Counter and strobe registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q       = q_q;
  assign sout_lo = q_q[0];
  assign sout_hi = q_q[DEPTH-1];
  assign cnt     = cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (DEPTH=8) against a bit-vector model.
module tb_univ_shift_reg;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             sin_lo = 1'b0;
  logic             sin_hi = 1'b0;
  logic [DEPTH-1:0] pdata = '0;
  logic             rot = 1'b0;
  logic [DEPTH-1:0] q;
  logic             sout_lo;
  logic             sout_hi;
  logic [CNT_W-1:0] cnt;
  logic             done;

  int tests = 0;
  int fails = 0;

  // Model state
  int  m_q    = 0;
  int  m_cnt  = 0;
  bit  m_done = 0;
  bit  m_ok   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .clr     (clr),
    .mode    (mode),
    .sin_lo  (sin_lo),
    .sin_hi  (sin_hi),
    .pdata   (pdata),
`ifdef SHREG_ROTATE_EN
    .rot     (rot),
`endif
    .q       (q),
    .sout_lo (sout_lo),
    .sout_hi (sout_hi),
    .cnt     (cnt),
    .done    (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, step the model from the rules, wait the edge.
  task automatic cyc(input logic [1:0] m, input logic sl, input logic sh,
                     input logic [7:0] pd, input logic c);
    int  nq, nc;
    bit  nd;
    int  in_lo, in_hi;
    mode = m; sin_lo = sl; sin_hi = sh; pdata = pd; clr = c;
    in_lo = sl;
    in_hi = sh;
`ifdef SHREG_ROTATE_EN
    if (rot) begin
      in_lo = (m_q >> 7) & 1;
      in_hi = m_q & 1;
    end
`endif
    nq = m_q; nc = m_cnt; nd = 0;
    if (!c) begin
      nq = 0; nc = 0;
    end else if (m == 2'b11) begin
      nq = pd; nc = 0;
    end else if (m == 2'b01 || m == 2'b10) begin
      if (m == 2'b01) nq = ((m_q * 2) + in_lo) % 256;
      else            nq = (m_q / 2) + in_hi * 128;
      if (m_cnt < DEPTH) begin
        nc = m_cnt + 1;
        nd = (nc == DEPTH);
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_cnt = nc; m_done = nd; m_ok = 1;
    $display("[TB] t=%0t mode=%0d clr=%0b sin_lo=%0b sin_hi=%0b pdata=%02h -> q=%02h cnt=%0d done=%0b",
             $time, m, c, sl, sh, pd, q, cnt, done);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("q",       int'(q),       m_q);
      chk("cnt",     int'(cnt),     m_cnt);
      chk("done",    int'(done),    int'(m_done));
      chk("sout_lo", int'(sout_lo), m_q & 1);
      chk("sout_hi", int'(sout_hi), (m_q >> 7) & 1);
    end
  end

  initial begin
    logic [7:0] pat;
    int done_seen;
    pat = 8'b1010_0101;

    // 1: reset overrides LOAD
    cyc(2'b11, 0, 0, 8'hFF, 0);
    chk("rst_q", int'(q), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_done", int'(done), 0);

    // 2: load then hold
    cyc(2'b11, 0, 0, 8'hA5, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 1, 1, 8'h00, 1);
      chk("hold_q", int'(q), 8'hA5);
      chk("hold_cnt", int'(cnt), 0);
      chk("hold_done", int'(done), 0);
    end

    // 3: eight shifts up, sout_hi reveals MSB-first
    cyc(2'b11, 0, 0, 8'hA5, 1);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      chk("pre_sout_hi", int'(sout_hi), int'(pat[7-k]));
      cyc(2'b01, 0, 0, 8'h00, 1);
      if (done) done_seen++;
      chk("up_done_lit", int'(done), (k == 7) ? 1 : 0);
    end
    chk("up_q8", int'(q), 0);
    chk("up_cnt8", int'(cnt), 8);
    chk("up_done_cnt", done_seen, 1);
    cyc(2'b01, 0, 0, 8'h00, 1);
    chk("sat_cnt", int'(cnt), 8);
    chk("sat_done", int'(done), 0);

    // 4: shift down from zero with sin_hi=1
    cyc(2'b11, 0, 0, 8'h00, 1);
    for (int k = 0; k < 3; k++) cyc(2'b10, 0, 1, 8'h00, 1);
    chk("dn_q", int'(q), 8'hE0);
    chk("dn_cnt", int'(cnt), 3);
    chk("dn_done", int'(done), 0);

    // 5: reset mid-frame, then resume counting
    cyc(2'b11, 0, 0, 8'h3C, 1);
    for (int k = 0; k < 4; k++) cyc(2'b01, 1, 0, 8'h00, 1);
    chk("mid_q", int'(q), 8'hCF);
    cyc(2'b01, 1, 0, 8'h00, 0);
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_cnt", int'(cnt), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, 0, 0, 8'h00, 1);
      chk("resume_done", int'(done), 0);
    end
    chk("resume_cnt", int'(cnt), 4);

    // Mixed directions still count toward the frame
    cyc(2'b11, 0, 0, 8'h5A, 1);
    for (int k = 0; k < 8; k++) cyc((k % 2 == 0) ? 2'b01 : 2'b10, k[0], ~k[0], 8'h00, 1);
    chk("mix_cnt", int'(cnt), 8);
    chk("mix_done", int'(done), 1);
    cyc(2'b00, 0, 0, 8'h00, 1);
    chk("mix_done_clr", int'(done), 0);

`ifdef SHREG_ROTATE_EN
    // 6: rotation
    cyc(2'b11, 0, 0, 8'h81, 1);
    rot = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(2'b01, 0, 0, 8'h00, 1);
      if (k == 0) chk("rot_q1", int'(q), 8'h03);
      if (done) done_seen++;
    end
    chk("rot_q8", int'(q), 8'h81);
    chk("rot_cnt", int'(cnt), 8);
    chk("rot_done_cnt", done_seen, 1);
    cyc(2'b10, 0, 1, 8'h00, 1);
    chk("rot_dn_q", int'(q), 8'hC0);
    rot = 1'b0;
`endif

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
